cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Coprocessor-0 exception/interrupt controller, the responder side of the fetch-stage PC redirect. It sits beside the memory stage, samples the victim instruction's PC, exception code and the six hardware interrupt lines each cycle, and decides whether to raise the exception request that forces the PC register to load the handler address. It also holds SR, Cause, EPC and PRId for mtc0/mfc0, and supplies the eret return address.

## Interface
- HANDLER_PC, 32'h0000_4180, handler entry driven on o_npc_exc while o_req is high
- PRID, 32'h2025_0007, constant returned for register 15
- i_clk  in  1  clock, all state updates on rising edge
- i_reset_n  in  1  reset, asynchronous, active-low; clears all state immediately
- i_we  in  1  mtc0 write enable (memory stage)
- i_addr  in  5  CP0 register number for mtc0/mfc0 (12 SR, 13 Cause, 14 EPC, 15 PRId)
- i_wdata  in  32  mtc0 write data
- i_vpc  in  32  PC of the instruction in the memory stage (bubbles carry the PC they replace)
- i_bd  in  1  memory-stage instruction is in a branch delay slot
- i_exccode  in  5  pending synchronous exception code, 0 = none
- i_eret  in  1  memory-stage instruction is eret
- i_hwint  in  6  hardware interrupt lines, level-sensitive, HWInt[5:0]
- o_req  out  1  exception/interrupt request to PC and pipeline flush (combinational)
- o_npc_exc  out  32  HANDLER_PC when o_req, else o_epc
- o_epc  out  32  return address for eret (forwarded, see Operation)
- o_rdata  out  32  mfc0 read data for i_addr (combinational)

## Operation
- SR fields: IM[15:10], EXL[1], IE[0]; other bits read 0, ignored on write.
- Cause fields: BD[31], IP[15:10], ExcCode[6:2]; other bits read 0. Cause is not writable by mtc0.
- EPC: 32 bits, low 2 bits forced to 0 on every write.
- int_req = IE & ~EXL & |(i_hwint & IM). exc_req = ~EXL & (i_exccode != 0). o_req = int_req | exc_req.
- Priority: interrupt over synchronous exception; ExcCode latched = 0 when int_req, else i_exccode.
- On o_req (next edge): EXL<=1; BD<=i_bd; ExcCode latched; EPC <= i_bd ? i_vpc-4 : i_vpc (32-bit wrap, low 2 bits cleared). mtc0 and eret in the same cycle are discarded.
- On i_eret without o_req: EXL<=0. eret and mtc0 together: both take effect; an mtc0 to SR wins on EXL.
- mtc0 without o_req: i_addr 12 writes SR fields, 14 writes EPC; 13, 15, others: no effect.
- Cause.IP <= i_hwint every cycle regardless of other events.
- o_epc = (i_we & i_addr==14) ? {i_wdata[31:2],2'b00} : EPC, so an eret directly after mtc0 EPC returns to the new value.
- o_rdata: 12 SR, 13 Cause, 14 EPC, 15 PRID, other addresses 0; reads registered values (no forwarding).

## Timing
- Reset (asynchronous assert, synchronous-safe release): SR=0, Cause=0, EPC=0; so o_req=0, o_epc=0, o_npc_exc=0, o_rdata=PRID only for addr 15.
- o_req, o_npc_exc, o_epc, o_rdata combinational from inputs and registers, zero latency; PC loads o_npc_exc on the same edge the CP0 state updates.
- EXL masks further requests from the cycle after acceptance until eret commits; a still-asserted i_hwint re-requests the cycle after eret if IE & IM allow.
- Reset low mid-handler clears EXL: requests re-enable only after software sets IE.

## Test plan
- Reset low with all inputs toggling -> o_req=0, SR/Cause/EPC read 0, PRId reads 32'h2025_0007; release -> unchanged.
- mtc0 SR=32'h0000_0401 then i_hwint=6'b000001, i_vpc=32'h0000_3010, i_bd=0 -> o_req=1, o_npc_exc=32'h4180; next cycle EPC=32'h3010, EXL=1, ExcCode=0, o_req=0.
- i_exccode=5'd10, i_bd=1, i_vpc=32'h0000_3024, EXL=0 -> EPC=32'h3020, BD=1, ExcCode=10; simultaneous i_we SR ignored.
- Interrupt and i_exccode=4 in same cycle with IE=1, IM enabled -> ExcCode=0 (interrupt wins).
- mtc0 EPC=32'h0000_3007 while i_eret=1 -> o_epc=32'h3004 that cycle, EXL cleared next edge.
- EXL=1 with i_exccode=12 and i_hwint=6'h3F -> o_req=0, no state change except Cause.IP=6'h3F.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt controller: SR/Cause/EPC/PRId, request and redirect
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h2025_0007
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_vpc,
  input  logic        i_bd,
  input  logic [4:0]  i_exccode,
  input  logic        i_eret,
  input  logic [5:0]  i_hwint,
  output logic        o_req,
  output logic [31:0] o_npc_exc,
  output logic [31:0] o_epc,
  output logic [31:0] o_rdata
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_we_sr;
  logic        w_we_epc;
  logic [31:0] w_victim_pc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_unused;

  assign w_int_req   = r_ie & ~r_exl & (|(i_hwint & r_im));
  assign w_exc_req   = ~r_exl & (i_exccode != 5'd0);
  // Held low while reset is asserted so the PC never redirects during reset.
  assign w_req       = i_reset_n & (w_int_req | w_exc_req);
  assign w_we_sr     = i_we & (i_addr == ADDR_SR);
  assign w_we_epc    = i_we & (i_addr == ADDR_EPC);
  assign w_victim_pc = i_bd ? (i_vpc - 32'd4) : i_vpc;
  assign w_unused    = ^{i_wdata[1:0], w_victim_pc[1:0]};

  assign w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
  assign w_cause = {r_bd, 15'h0000, r_ip, 3'b000, r_exccode, 2'b00};

  assign o_req     = w_req;
  // Forward an in-flight mtc0 EPC so an eret right behind it returns to the new address.
  assign o_epc     = w_we_epc ? {i_wdata[31:2], 2'b00} : r_epc;
  assign o_npc_exc = w_req ? HANDLER_PC : o_epc;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= i_hwint;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_bd      <= i_bd;
        r_exccode <= w_int_req ? 5'd0 : i_exccode;
        r_epc     <= {w_victim_pc[31:2], 2'b00};
      end else begin
        if (i_eret) begin
          r_exl <= 1'b0;
        end
        // Ordered after eret so an mtc0 SR in the same cycle decides EXL.
        if (w_we_sr) begin
          r_im  <= i_wdata[15:10];
          r_exl <= i_wdata[1];
          r_ie  <= i_wdata[0];
        end
        if (w_we_epc) begin
          r_epc <= {i_wdata[31:2], 2'b00};
        end
      end
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      ADDR_SR:    o_rdata = w_sr;
      ADDR_CAUSE: o_rdata = w_cause;
      ADDR_EPC:   o_rdata = r_epc;
      ADDR_PRID:  o_rdata = PRID;
      default:    o_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - scoreboard bench for cp0_exc_ctrl
`timescale 1ns/1ps
module tb_cp0_exc_ctrl;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] PRID       = 32'h2025_0007;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_we;
  logic [4:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] i_vpc;
  logic        i_bd;
  logic [4:0]  i_exccode;
  logic        i_eret;
  logic [5:0]  i_hwint;
  logic        o_req;
  logic [31:0] o_npc_exc;
  logic [31:0] o_epc;
  logic [31:0] o_rdata;

  cp0_exc_ctrl dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_vpc(i_vpc), .i_bd(i_bd), .i_exccode(i_exccode), .i_eret(i_eret), .i_hwint(i_hwint),
    .o_req(o_req), .o_npc_exc(o_npc_exc), .o_epc(o_epc), .o_rdata(o_rdata)
  );

  always #50 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic idle();
    i_we = 1'b0; i_addr = 5'd0; i_wdata = 32'd0; i_vpc = 32'd0;
    i_bd = 1'b0; i_exccode = 5'd0; i_eret = 1'b0; i_hwint = 6'd0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input string n, input logic [4:0] a, input logic [31:0] v);
    exp_t e;
    e.name = n; e.addr = a; e.val = v;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    idle();
    repeat (3) begin
      i_we = 1'($urandom); i_addr = 5'($urandom); i_wdata = $urandom; i_vpc = $urandom;
      i_bd = 1'($urandom); i_exccode = 5'($urandom_range(1, 31)); i_eret = 1'($urandom);
      i_hwint = 6'($urandom);
      #1;
      checks++;
      if (o_req !== 1'b0) begin errors++; $display("FAIL reset_req: o_req=%b expected 0", o_req); end
      tick();
    end
    idle();
    push("reset_sr", 5'd12, 32'd0); push("reset_cause", 5'd13, 32'd0);
    push("reset_epc", 5'd14, 32'd0); push("reset_prid", 5'd15, PRID);
    #1;
    checks++;
    if (o_epc !== 32'd0) begin errors++; $display("FAIL reset_o_epc: got %h expected 0", o_epc); end
    checks++;
    if (o_npc_exc !== 32'd0) begin errors++; $display("FAIL reset_npc: got %h expected 0", o_npc_exc); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
    i_reset_n = 1'b1;
    tick();
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL release_req: o_req=%b expected 0", o_req); end
    push("release_sr", 5'd12, 32'd0); push("release_cause", 5'd13, 32'd0);
    push("release_epc", 5'd14, 32'd0); push("release_prid", 5'd15, PRID);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
  endtask

  task automatic test_interrupt();
    exp_t e;
    tick();
    i_we = 1'b1; i_addr = 5'd12; i_wdata = 32'h0000_0401;
    tick();
    idle();
    i_hwint = 6'b000001; i_vpc = 32'h0000_3010;
    #1;
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL int_req: o_req=%b expected 1", o_req); end
    checks++;
    if (o_npc_exc !== HANDLER_PC) begin errors++; $display("FAIL int_npc: got %h expected %h", o_npc_exc, HANDLER_PC); end
    tick();
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL int_exl_mask: o_req=%b expected 0", o_req); end
    push("int_epc", 5'd14, 32'h0000_3010); push("int_sr", 5'd12, 32'h0000_0403);
    push("int_cause", 5'd13, 32'h0000_0400);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
    i_eret = 1'b1;
    tick();
    i_eret = 1'b0;
    #1;
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL int_rerequest: o_req=%b expected 1", o_req); end
    push("int_after_eret_sr", 5'd12, 32'h0000_0401);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
    idle();
  endtask

  task automatic test_exception();
    exp_t e;
    tick();
    i_exccode = 5'd10; i_bd = 1'b1; i_vpc = 32'h0000_3024;
    i_we = 1'b1; i_addr = 5'd12; i_wdata = 32'd0;
    #1;
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL exc_req: o_req=%b expected 1", o_req); end
    tick();
    idle();
    push("exc_epc", 5'd14, 32'h0000_3020); push("exc_cause", 5'd13, 32'h8000_0028);
    push("exc_sr_ignored", 5'd12, 32'h0000_0403);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
    i_eret = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_priority();
    exp_t e;
    tick();
    i_hwint = 6'b000001; i_exccode = 5'd4; i_vpc = 32'h0000_3100;
    #1;
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL prio_req: o_req=%b expected 1", o_req); end
    tick();
    idle();
    push("prio_cause", 5'd13, 32'h0000_0400); push("prio_epc", 5'd14, 32'h0000_3100);
    push("prio_sr", 5'd12, 32'h0000_0403);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
    tick();
    push("prio_ip_follow", 5'd13, 32'h0000_0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
    i_eret = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_eret_forward();
    exp_t e;
    tick();
    i_exccode = 5'd8; i_vpc = 32'h0000_3200;
    tick();
    idle();
    i_we = 1'b1; i_addr = 5'd14; i_wdata = 32'h0000_3007; i_eret = 1'b1;
    #1;
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL fwd_req: o_req=%b expected 0", o_req); end
    checks++;
    if (o_epc !== 32'h0000_3004) begin errors++; $display("FAIL fwd_epc: got %h expected 00003004", o_epc); end
    checks++;
    if (o_npc_exc !== 32'h0000_3004) begin errors++; $display("FAIL fwd_npc: got %h expected 00003004", o_npc_exc); end
    tick();
    idle();
    push("fwd_sr_exl_clear", 5'd12, 32'h0000_0401); push("fwd_epc_reg", 5'd14, 32'h0000_3004);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
    i_exccode = 5'd8; i_vpc = 32'h0000_3200;
    tick();
    idle();
    i_eret = 1'b1; i_we = 1'b1; i_addr = 5'd12; i_wdata = 32'h0000_0403;
    tick();
    idle();
    push("eret_sr_wins", 5'd12, 32'h0000_0403);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
  endtask

  task automatic test_exl_mask();
    exp_t e;
    tick();
    i_exccode = 5'd12; i_hwint = 6'h3F;
    #1;
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL mask_req: o_req=%b expected 0", o_req); end
    checks++;
    if (o_npc_exc !== 32'h0000_3200) begin errors++; $display("FAIL mask_npc: got %h expected 00003200", o_npc_exc); end
    tick();
    idle();
    push("mask_cause", 5'd13, 32'h0000_FC20); push("mask_epc", 5'd14, 32'h0000_3200);
    push("mask_sr", 5'd12, 32'h0000_0403);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
    i_eret = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    tick();
    i_bd = 1'b1; i_vpc = 32'h0000_0002; i_exccode = 5'd1;
    tick();
    idle();
    i_we = 1'b1; i_addr = 5'd13; i_wdata = 32'hFFFF_FFFF;
    tick();
    i_addr = 5'd15;
    tick();
    i_addr = 5'd20;
    tick();
    idle();
    push("wrap_epc", 5'd14, 32'hFFFF_FFFC); push("cause_not_writable", 5'd13, 32'h8000_0004);
    push("prid_const", 5'd15, PRID); push("unmapped_addr", 5'd20, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
  endtask

  task automatic test_reset_midhandler();
    exp_t e;
    tick();
    i_reset_n = 1'b0;
    #1;
    i_reset_n = 1'b1;
    i_hwint = 6'b000001;
    #1;
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL midreset_req: o_req=%b expected 0", o_req); end
    push("midreset_sr", 5'd12, 32'd0); push("midreset_epc", 5'd14, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); i_addr = e.addr; #1; checks++;
      if (o_rdata !== e.val) begin errors++; $display("FAIL %s: o_rdata=%h expected %h", e.name, o_rdata, e.val); end
    end
    i_we = 1'b1; i_addr = 5'd12; i_wdata = 32'h0000_0401;
    tick();
    i_we = 1'b0;
    #1;
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL midreset_reenable: o_req=%b expected 1", o_req); end
    idle();
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception();
    test_priority();
    test_eret_forward();
    test_exl_mask();
    test_back_to_back();
    test_reset_midhandler();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: left=%0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
